// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
// Multi-pass sequencer wrapped around the external 8-bit combinational barrel
// shifter. A 0-15 shift request is broken into passes of at most 7 positions,
// looping the shifter result back through an accumulator until the requested
// amount has been consumed. The final value is then held on a valid/ready port.

module shift_seq_ctrl (
    input  logic       clk,
    input  logic       rst,

    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [3:0] in_amt,
    input  logic       in_lr,
    input  logic       in_al,

    output logic [7:0] sh_din,
    output logic [2:0] sh_shamt,
    output logic       sh_lr,
    output logic       sh_al,
    input  logic [7:0] sh_dout,

    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [1:0] out_passes
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_d;

    logic [7:0] acc;
    logic [7:0] acc_d;
    logic [3:0] rem;
    logic [3:0] rem_d;
    logic       lr_q;
    logic       lr_d;
    logic       al_q;
    logic       al_d;
    logic [1:0] pass_q;
    logic [1:0] pass_d;

    logic [2:0] step;
    logic [3:0] rem_after;

    // Size of the next pass: the shifter only takes 0-7, so cap at 7.
    always_comb begin
        step      = (rem > 4'd7) ? 3'd7 : rem[2:0];
        rem_after = rem - {1'b0, step};
    end

    // Shifter drive and result port are plain views of the registered state,
    // so every sh_* output only moves on a clock edge.
    always_comb begin
        sh_din     = acc;
        sh_lr      = lr_q;
        sh_al      = al_q;
        sh_shamt   = (state == SHIFT) ? step : 3'd0;
        out_data   = acc;
        out_passes = pass_q;
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
    end

    // Next-state and datapath update: load in IDLE, one pass per cycle in
    // SHIFT, and hold everything steady in DONE until the consumer takes it.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        rem_d   = rem;
        lr_d    = lr_q;
        al_d    = al_q;
        pass_d  = pass_q;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    rem_d   = in_amt;
                    lr_d    = in_lr;
                    al_d    = in_al;
                    pass_d  = 2'd0;
                    state_d = (in_amt == 4'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_d  = sh_dout;
                rem_d  = rem_after;
                pass_d = pass_q + 2'd1;
                if (rem_after == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= 8'h00;
            rem    <= 4'd0;
            lr_q   <= 1'b0;
            al_q   <= 1'b0;
            pass_q <= 2'd0;
        end else begin
            state  <= state_d;
            acc    <= acc_d;
            rem    <= rem_d;
            lr_q   <= lr_d;
            al_q   <= al_d;
            pass_q <= pass_d;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl
// Closes the loop with a behavioural 8-bit barrel shifter and checks every
// command against a direct whole-amount shift computed with plain arithmetic.

module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_amt;
    logic       in_lr;
    logic       in_al;
    logic [7:0] sh_din;
    logic [2:0] sh_shamt;
    logic       sh_lr;
    logic       sh_al;
    logic [7:0] sh_dout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_passes;

    int checks = 0;
    int errors = 0;

    shift_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_lr      (in_lr),
        .in_al      (in_al),
        .sh_din     (sh_din),
        .sh_shamt   (sh_shamt),
        .sh_lr      (sh_lr),
        .sh_al      (sh_al),
        .sh_dout    (sh_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_passes (out_passes)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // The external combinational barrel shifter the sequencer drives.
    always_comb begin
        logic signed [7:0] s;
        s = sh_din;
        if (sh_lr)
            sh_dout = sh_din << sh_shamt;
        else if (sh_al)
            sh_dout = s >>> sh_shamt;
        else
            sh_dout = sh_din >> sh_shamt;
    end

    // Reference: the whole shift done in one go on integers.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt,
                                             input logic lr, input logic al);
        int r;
        if (lr) begin
            r = (int'(d) << amt) & 255;
        end else if (al) begin
            r = int'(d);
            if (d[7]) r = r - 256;
            r = r >>> amt;
        end else begin
            r = int'(d) >> amt;
        end
        return 8'(r);
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full command: waits for in_ready, checks every pass, holds
    // the result under backpressure for hold_cycles, then completes it.
    task automatic applyStimulus(input logic [7:0] d, input int amt, input logic lr,
                                 input logic al, input int hold_cycles);
        int wait_cnt;
        int p;
        int done_amt;
        int step;
        logic [7:0] exp;
        wait_cnt = 0;
        while (in_ready !== 1'b1 && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("ready_timeout", 16'(in_ready), 16'd1);
            return;
        end
        checkOutput("idle_shamt", 16'(sh_shamt), 16'd0);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = 4'(amt);
        in_lr    = lr;
        in_al    = al;
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_amt   = 4'($urandom);
        in_lr    = 1'($urandom);
        in_al    = 1'($urandom);

        p = (amt + 6) / 7;
        done_amt = 0;
        for (int k = 0; k < p; k++) begin
            step = (amt - done_amt > 7) ? 7 : amt - done_amt;
            checkOutput("pass_out_valid", 16'(out_valid), 16'd0);
            checkOutput("pass_in_ready", 16'(in_ready), 16'd0);
            checkOutput("pass_shamt", 16'(sh_shamt), 16'(step));
            checkOutput("pass_din", 16'(sh_din), 16'(ref_shift(d, done_amt, lr, al)));
            checkOutput("pass_lr", 16'(sh_lr), 16'(lr));
            done_amt += step;
            tick();
        end

        exp = ref_shift(d, amt, lr, al);
        checkOutput("out_valid", 16'(out_valid), 16'd1);
        checkOutput("out_data", 16'(out_data), 16'(exp));
        checkOutput("out_passes", 16'(out_passes), 16'(p));
        checkOutput("done_shamt", 16'(sh_shamt), 16'd0);

        for (int h = 0; h < hold_cycles; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            in_amt    = 4'($urandom);
            tick();
            checkOutput("hold_valid", 16'(out_valid), 16'd1);
            checkOutput("hold_data", 16'(out_data), 16'(exp));
            checkOutput("hold_passes", 16'(out_passes), 16'(p));
            checkOutput("hold_in_ready", 16'(in_ready), 16'd0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("release_in_ready", 16'(in_ready), 16'd1);
        checkOutput("release_out_valid", 16'(out_valid), 16'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_amt    = 4'd0;
        in_lr     = 1'b0;
        in_al     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("rst_in_ready", 16'(in_ready), 16'd1);
        checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
        checkOutput("rst_out_data", 16'(out_data), 16'h00);
        checkOutput("rst_out_passes", 16'(out_passes), 16'd0);
        checkOutput("rst_sh_din", 16'(sh_din), 16'h00);
        checkOutput("rst_sh_shamt", 16'(sh_shamt), 16'd0);
        checkOutput("rst_sh_lr", 16'(sh_lr), 16'd0);
        checkOutput("rst_sh_al", 16'(sh_al), 16'd0);

        // Directed cases from the intended use.
        applyStimulus(8'hA5, 0, 1'b1, 1'b0, 0);
        applyStimulus(8'h81, 3, 1'b1, 1'b0, 5);
        applyStimulus(8'hFF, 9, 1'b0, 1'b0, 1);
        applyStimulus(8'h80, 15, 1'b0, 1'b1, 0);
        applyStimulus(8'h7F, 15, 1'b0, 1'b1, 2);
        applyStimulus(8'hC3, 7, 1'b0, 1'b1, 0);
        applyStimulus(8'h5A, 14, 1'b1, 1'b0, 0);
        applyStimulus(8'h96, 8, 1'b0, 1'b0, 0);

        // Reset in the middle of the second pass discards the operation.
        in_valid = 1'b1;
        in_data  = 8'h80;
        in_amt   = 4'd15;
        in_lr    = 1'b0;
        in_al    = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("mid_shamt", 16'(sh_shamt), 16'd7);
        checkOutput("mid_din", 16'(sh_din), 16'hFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mrst_in_ready", 16'(in_ready), 16'd1);
        checkOutput("mrst_out_valid", 16'(out_valid), 16'd0);
        checkOutput("mrst_out_data", 16'(out_data), 16'h00);
        checkOutput("mrst_out_passes", 16'(out_passes), 16'd0);
        checkOutput("mrst_sh_shamt", 16'(sh_shamt), 16'd0);
        checkOutput("mrst_sh_al", 16'(sh_al), 16'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("mrst_no_stale", 16'(out_valid), 16'd0);
        end

        // Back-to-back: out_ready tied high, in_valid held.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        in_amt    = 4'd1;
        in_lr     = 1'b1;
        in_al     = 1'b0;
        tick();
        in_data = 8'h40;
        in_amt  = 4'd14;
        in_lr   = 1'b0;
        in_al   = 1'b0;
        checkOutput("b2b_shamt1", 16'(sh_shamt), 16'd1);
        checkOutput("b2b_busy", 16'(in_ready), 16'd0);
        tick();
        checkOutput("b2b_valid1", 16'(out_valid), 16'd1);
        checkOutput("b2b_data1", 16'(out_data), 16'h02);
        checkOutput("b2b_passes1", 16'(out_passes), 16'd1);
        tick();
        checkOutput("b2b_idle", 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("b2b_accept2", 16'(sh_shamt), 16'd7);
        checkOutput("b2b_din2", 16'(sh_din), 16'h40);
        tick();
        checkOutput("b2b_shamt2b", 16'(sh_shamt), 16'd7);
        tick();
        checkOutput("b2b_valid2", 16'(out_valid), 16'd1);
        checkOutput("b2b_data2", 16'(out_data), 16'h00);
        checkOutput("b2b_passes2", 16'(out_passes), 16'd2);
        tick();
        out_ready = 1'b0;
        checkOutput("b2b_end_idle", 16'(in_ready), 16'd1);

        // Randomized commands against the reference.
        for (int n = 0; n < 40; n++) begin
            applyStimulus(8'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                          1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
